// File: rtl/key_pkg.sv
// Shared types and constants for the key event front-end and its consumers.
package key_pkg;

    localparam int unsigned N_KEYS    = 8;
    localparam int unsigned KEY_IDX_W = 3;

    // Event word: is_release = 0 for a press (falling edge), 1 for a release (rising edge).
    typedef struct packed {
        logic                 is_release;
        logic [KEY_IDX_W-1:0] code;
    } key_evt_t;

    function automatic logic [KEY_IDX_W-1:0] lowest_set(input logic [N_KEYS-1:0] v);
        logic [KEY_IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = KEY_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One button channel: two-flop synchroniser, persistence counter and debounced level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic level_o,
    output logic flip_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        flip_o   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                flip_o   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

endmodule

// File: rtl/key_event_frontend.sv
// Debounces eight active-low buttons and queues press/release events behind a
// valid/ready handshake, with a sticky flag for any event that had to be dropped.
module key_event_frontend
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_code,
    output logic              evt_release,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [N_KEYS-1:0] flip;
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [N_KEYS-1:0] ptype_q, ptype_d;
    logic              overflow_q, overflow_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    key_evt_t          mem_q [FIFO_DEPTH];

    logic                 grant_valid;
    logic [KEY_IDX_W-1:0] grant_idx;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop, drop, collision;
    key_evt_t             push_evt, head_evt;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i  (clk_50M),
            .rst_i  (rst),
            .key_i  (key_in[i]),
            .level_o(key_level[i]),
            .flip_o (flip[i])
        );
    end

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop        = !fifo_empty && evt_ready;

    assign grant_valid = |pending_q;
    assign grant_idx   = lowest_set(pending_q);

    // A pop on the same edge frees a slot, so the push is still accepted.
    assign push = grant_valid && (!fifo_full || pop);
    assign drop = grant_valid && fifo_full && !pop;

    always_comb begin
        push_evt.is_release = ptype_q[grant_idx];
        push_evt.code       = grant_idx;
    end

    always_comb begin
        pending_d = pending_q;
        ptype_d   = ptype_q;
        collision = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (grant_valid && (grant_idx == KEY_IDX_W'(i))) begin
                pending_d[i] = 1'b0;
            end else if (flip[i] && pending_q[i]) begin
                collision = 1'b1;
            end
            // The debounced level is about to invert, so the new type is its complement.
            if (flip[i]) begin
                pending_d[i] = 1'b1;
                ptype_d[i]   = ~key_level[i];
            end
        end
    end

    always_comb begin
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        overflow_d = overflow_q;
        if (ovf_clr) overflow_d = 1'b0;
        if (drop || collision) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            pending_q  <= '0;
            ptype_q    <= '0;
            overflow_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            ptype_q    <= ptype_d;
            overflow_q <= overflow_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst && push) begin
            mem_q[wptr_q[AW-1:0]] <= push_evt;
        end
    end

    assign head_evt    = mem_q[rptr_q[AW-1:0]];
    assign evt_valid   = !fifo_empty;
    assign evt_code    = evt_valid ? head_evt.code : 3'd0;
    assign evt_release = evt_valid ? head_evt.is_release : 1'b0;
    assign overflow    = overflow_q;

endmodule

// File: doc/key_event_frontend.md
# key_event_frontend

Front-end stage that sits directly upstream of the top-level control logic. It synchronises and debounces the eight active-low push-buttons on `key_in[7:0]` and converts each debounced press or release into a one-word key event. Events are buffered in a 4-deep FIFO and handed downstream over a valid/ready handshake. Downstream logic therefore never sees raw button levels or bounce.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a new level must persist before it is accepted (20 ms at 50 MHz). Minimum value is 2.
- `FIFO_DEPTH`, default 4: event buffer depth. Must be a power of two, 2 or more.
- `clk_50M`  in  1  system clock. Single clock domain; synchronous reset, active-high.
- `rst`  in  1  synchronous, active-high reset.
- `key_in`  in  8  raw buttons. Active-low and asynchronous.
- `key_level`  out  8  debounced levels, active-low.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_code`  out  3  key index of the head event.
- `evt_release`  out  1  head event type: 0 = press (falling edge), 1 = release (rising edge).
- `overflow`  out  1  sticky flag: an event was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- **Synchroniser:** two flops per key, both reset to 1.
- **Debouncer (per key):**
  - Holds a `stable` level (reset 1) and a counter (reset 0).
  - While `sync2 != stable`, the counter increments each cycle.
  - At the edge where the counter equals `DEBOUNCE_CYCLES-1` and the mismatch still holds: `stable <= sync2`, counter <= 0, and the key's `pending` flag is set with type = new `stable`.
  - If `sync2 == stable` at any point, the counter returns to 0. A glitch shorter than the window therefore produces nothing.
- **Arbiter:**
  - Each cycle, the lowest-index key with `pending` set is granted.
  - The grant pushes {type, index} into the FIFO and clears that key's `pending` in the same cycle.
  - At most one push per cycle.
  - Several keys can flip on the same edge. They drain on consecutive cycles in index order.
- **Pending collision:** a key flips again while its `pending` is still set. The newer type overwrites the older one, and `overflow` is set.
- **FIFO full:**
  - The granted event is dropped, `pending` is still cleared, and `overflow` is set.
  - If a pop happens in the same cycle as the push, the FIFO is not full for this purpose and the push succeeds.
- **Handshake:**
  - A pop occurs on a clock edge where `evt_valid && evt_ready`.
  - `evt_code` and `evt_release` are held stable while `evt_valid && !evt_ready`.
  - `evt_ready` asserted while the FIFO is empty has no effect.
- **Overflow flag:**
  - `overflow` is set by a drop or a collision and cleared by `ovf_clr`.
  - If a set and `ovf_clr` occur in the same cycle, set wins.
- **FIFO pointers:** `$clog2(FIFO_DEPTH)+1` bits each; they wrap naturally. Full/empty is decided by MSB compare.

## Timing
- **Reset values:**
  - `key_level` = 8'hFF.
  - `evt_valid` = 0, `evt_code` = 0, `evt_release` = 0, `overflow` = 0.
  - All `pending` flags, counters and FIFO pointers = 0.
- **Latency, key change to level:** `key_in` changes and is first sampled at edge k. `key_level` changes after edge k+1+`DEBOUNCE_CYCLES`.
- **Latency, single event to output:** arbitration takes one cycle, so the push happens at edge k+2+`DEBOUNCE_CYCLES`. `evt_valid` is high after that edge, for a total of `DEBOUNCE_CYCLES`+3 edges from first sample.
- **Throughput:** one event per cycle in and one per cycle out. A simultaneous push and pop on a non-empty FIFO keeps the occupancy unchanged.
- **Reset mid-operation:**
  - Partial counts, pending events and FIFO contents are discarded.
  - A key held down through reset is reported as a press once it has been stable for `DEBOUNCE_CYCLES` after reset is released.

## Structure
- **Package `key_pkg`:**
  - `N_KEYS = 8`.
  - `KEY_IDX_W = 3`.
  - Typedef `key_evt_t` as a packed struct {`release`, `code[2:0]`}, reused by downstream consumers.
- **Sub-module `key_debounce`:** one channel containing the synchroniser, counter, `stable` register and a one-cycle `flip` strobe. Instantiated 8× via generate.
- **Top of this block:** the arbiter, the FIFO and the overflow logic stay in `key_event_frontend`.

## Test plan
All benches use `DEBOUNCE_CYCLES` = 16.
- **Single press/release:** `key_in[0]` goes low for 1500 cycles, then high, with `evt_ready`=1. Expect an event {0, code 0} 19 edges after the fall and an event {1, code 0} 19 edges after the rise; `key_level[0]` follows both edges.
- **Bounce rejection:** `key_in[4]` toggles every 5 cycles for 60 cycles, then stays low. Expect exactly one press event with code 4, issued 19 edges after the final fall; `overflow` stays 0.
- **Simultaneous keys:** `key_in[5]` and `key_in[3]` fall on the same cycle with `evt_ready`=1. Expect code 3 then code 5 on consecutive cycles.
- **Backpressure and overflow:** hold `evt_ready`=0 and press/release keys 0, 3 and 4 (6 events). Expect the first 4 events to be retained in order, `overflow` set, then drained in order once `evt_ready`=1; `ovf_clr` clears `overflow`.
- **Handshake stability:** `evt_ready` toggles every other cycle. Expect `evt_code`/`evt_release` unchanged while `evt_valid && !evt_ready`, and no duplicate or lost events.
- **Reset mid-debounce:** assert `rst` at counter 10 on key 0 while `key_in[0]` stays low. Expect outputs at reset values, then a press event `DEBOUNCE_CYCLES`+3 edges after `rst` deasserts.
